// File: rtl/imm_gen_stage.sv
// LEGv8 immediate-generation stage: decodes each instruction into a 64-bit
// immediate plus operand-select flag, behind a 2-entry valid/ready skid buffer.
module imm_gen_stage #(
  parameter int DATA_W  = 64,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  immed,
  output logic               flag,
  output logic               illegal
);

  // state | meaning
  // EMPTY | no word held, output invalid
  // ONE   | head register holds the oldest word
  // FULL  | head and skid both hold words, input stalled
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

  state_t state, state_next;

  logic [DATA_W-1:0] dec_immed, head_immed, skid_immed;
  logic              dec_flag, head_flag, skid_flag;
  logic              dec_illegal, head_illegal, skid_illegal;
  logic              in_ready_q;
  logic              accept, pop;
  logic              load_head_new, load_head_skid, load_skid;

  // Encodings are disjoint; the if-chain order only guards against overlap.
  always_comb begin
    dec_immed   = '0;
    dec_flag    = 1'b0;
    dec_illegal = 1'b0;
    if (instr[31:26] == 6'b000101) begin
      dec_immed = {{(DATA_W-28){instr[25]}}, instr[25:0], 2'b00};
    end else if (instr[31:24] == 8'b10110100) begin
      dec_immed = {{(DATA_W-21){instr[23]}}, instr[23:5], 2'b00};
    end else if (instr[31:22] == 10'b1001000100 || instr[31:22] == 10'b1101000100) begin
      dec_immed = {{(DATA_W-12){1'b0}}, instr[21:10]};
      dec_flag  = 1'b1;
    end else if (instr[31:21] == 11'b11111000010 || instr[31:21] == 11'b11111000000) begin
      dec_immed = {{(DATA_W-9){instr[20]}}, instr[20:12]};
      dec_flag  = 1'b1;
    end else if (instr[31:21] == 11'b10001011000 || instr[31:21] == 11'b11001011000 ||
                 instr[31:21] == 11'b10001010000 || instr[31:21] == 11'b10101010000) begin
      dec_immed = '0;
    end else begin
      dec_illegal = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (accept) state_next = ONE;
      ONE: begin
        if (accept && !pop)      state_next = FULL;
        else if (!accept && pop) state_next = EMPTY;
      end
      FULL:    if (pop) state_next = ONE;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    out_valid      = (state != EMPTY);
    accept         = in_valid && in_ready_q;
    pop            = out_valid && out_ready;
    load_head_new  = accept && ((state == EMPTY) || (state == ONE && pop));
    load_skid      = accept && (state == ONE) && !pop;
    load_head_skid = (state == FULL) && pop;
  end

  // Registered ready: low through reset, and never a function of out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) in_ready_q <= 1'b0;
    else        in_ready_q <= (state_next != FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_immed   <= '0;
      head_flag    <= 1'b0;
      head_illegal <= 1'b0;
      skid_immed   <= '0;
      skid_flag    <= 1'b0;
      skid_illegal <= 1'b0;
    end else begin
      if (load_head_new) begin
        head_immed   <= dec_immed;
        head_flag    <= dec_flag;
        head_illegal <= dec_illegal;
      end else if (load_head_skid) begin
        head_immed   <= skid_immed;
        head_flag    <= skid_flag;
        head_illegal <= skid_illegal;
      end
      if (load_skid) begin
        skid_immed   <= dec_immed;
        skid_flag    <= dec_flag;
        skid_illegal <= dec_illegal;
      end
    end
  end

  assign in_ready = in_ready_q;
  assign immed    = head_immed;
  assign flag     = head_flag;
  assign illegal  = head_illegal;

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Pipelined immediate-generation stage for the 64-bit LEGv8 datapath. It is the producer side of the ALU-operand select: it decodes each 32-bit instruction and produces the 64-bit immediate and the select flag that the operand mux consumes.
- It sits between instruction fetch and the execute-operand select.
- Valid/ready on both sides, with a 2-entry skid buffer, so fetch stalls never drop or duplicate instructions.

Parameters:
- DATA_W, 64, width of the generated immediate.
- INSTR_W, 32, instruction width; fixed at 32, other values unsupported.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  instr is valid this cycle.
- in_ready  output  1  stage can accept instr this cycle.
- instr  input  32  LEGv8 instruction word.
- out_valid  output  1  immed/flag/illegal are valid.
- out_ready  input  1  downstream accepts the output this cycle.
- immed  output  64  sign- or zero-extended immediate.
- flag  output  1  operand select: 1 = use immed, 0 = use register data.
- illegal  output  1  opcode not recognised.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is asynchronous, active-low, named rst_n.
  - While rst_n=0: out_valid=0, immed=0, flag=0, illegal=0, both buffer entries empty, in_ready=0.
  - in_ready rises on the first rising edge after rst_n deasserts.
  - Reset mid-transfer discards all buffered entries; nothing in flight is replayed.
- Decode (combinational on instr, registered on accept):
  - ADDI: [31:22]=1001000100. immed = zero-extended instr[21:10]. flag=1.
  - SUBI: [31:22]=1101000100. immed = zero-extended instr[21:10]. flag=1.
  - LDUR: [31:21]=11111000010. immed = sign-extended instr[20:12]. flag=1.
  - STUR: [31:21]=11111000000. immed = sign-extended instr[20:12]. flag=1.
  - CBZ: [31:24]=10110100. immed = sign-extended {instr[23:5],2'b00}. flag=0.
  - B: [31:26]=000101. immed = sign-extended {instr[25:0],2'b00}. flag=0.
  - ADD/SUB/AND/ORR (R-type: 10001011000, 11001011000, 10001010000, 10101010000): immed=0, flag=0.
  - Anything else: immed=0, flag=0, illegal=1. The word still flows through the stage; it is not dropped.
  - Match priority: B, CBZ, 10-bit opcodes, 11-bit opcodes. The encodings are disjoint, so priority only matters for robustness.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - instr is ignored when in_valid=0.
  - Outputs are stable while out_valid && !out_ready.
- Latency: 1 cycle. A word accepted at edge N appears with out_valid=1 after edge N, provided the buffer was empty.
- Buffer: 2 entries (head = output register, skid = second entry). States: EMPTY, ONE, FULL.
  - EMPTY: accept → ONE.
  - ONE: accept without pop → FULL. Pop without accept → EMPTY. Accept and pop in the same cycle → ONE, with the new word in head.
  - FULL: pop → ONE; skid moves to head.
  - in_ready = (state != FULL), registered. in_ready never depends combinationally on out_ready.
  - out_valid = (state != EMPTY).
- Ordering: strict FIFO; throughput is 1 word/cycle when out_ready is held at 1.

Test Plan:
- Reset, then in_valid=1, instr=0x91001441 (ADDI X1,X2,#5), out_ready=1 → next cycle: out_valid=1, immed=0x0000000000000005, flag=1, illegal=0.
- instr=0xF85F8083 (LDUR X3,[X4,#-8]) → immed=0xFFFFFFFFFFFFFFF8, flag=1.
- instr=0xB4FFFFE0 (CBZ, offset -1) → immed=0xFFFFFFFFFFFFFFFC, flag=0. Then instr=0x14000003 (B +3) → immed=0x000000000000000C, flag=0.
- instr=0x8B020020 (ADD) → immed=0, flag=0, illegal=0. Then instr=0xFFFFFFFF → immed=0, flag=0, illegal=1.
- Backpressure: out_ready=0, present 3 back-to-back words A,B,C → A and B accepted, in_ready=0 from the cycle after B, C held. Raise out_ready → outputs A,B,C in order, no loss or duplication, 1 per cycle.
- Buffer FULL, then pull rst_n low between edges → out_valid=0, immed=0, flag=0 immediately without a clock edge. After release, in_ready=1 on the next edge and no old data emerges.
